// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder and the register logic that consumes its commands.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StOp,
    StAddr,
    StData,
    StChk,
    StHold
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  // SYNC + OP + ADDR + 4 data bytes + CHK
  localparam int unsigned FRAME_LEN         = 8;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_WRITE      = 8'h01;
  localparam logic [7:0] OP_READ       = 8'h02;
  localparam logic [7:0] OP_GLITCH_ARM = 8'h10;
  localparam logic [7:0] OP_EXI_XFER   = 8'h20;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Frames SYNC/OP/ADDR/D0..D3/CHK packets from the UART byte stream and presents validated
// commands on a valid/ready interface; bad or truncated packets are dropped with error pulses.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_eop,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        err_chk,
  output logic        err_frame,
  output logic        err_ovr,
  output logic        busy
);

  localparam logic [1:0] LastIdx = 2'(DATA_BYTES - 1);

  state_e      state_q;
  logic [7:0]  acc_q;
  logic [1:0]  cnt_q;
  logic [7:0]  op_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;

  logic sync_hit;
  assign sync_hit = rx_ready && (rx_data == SYNC_BYTE);
  assign busy     = (state_q != StHunt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHunt;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      err_chk   <= 1'b0;
      err_frame <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      err_chk   <= 1'b0;
      err_frame <= 1'b0;
      err_ovr   <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (sync_hit) begin
            state_q <= StOp;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StOp: begin
          if (rx_ready) begin
            op_q    <= rx_data;
            acc_q   <= acc_q ^ rx_data;
            state_q <= StAddr;
          end else if (rx_eop) begin
            err_frame <= 1'b1;
            state_q   <= StHunt;
          end
        end
        StAddr: begin
          if (rx_ready) begin
            addr_q  <= rx_data;
            acc_q   <= acc_q ^ rx_data;
            state_q <= StData;
          end else if (rx_eop) begin
            err_frame <= 1'b1;
            state_q   <= StHunt;
          end
        end
        StData: begin
          if (rx_ready) begin
            // Little-endian: first payload byte lands in [7:0]
            data_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            acc_q <= acc_q ^ rx_data;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LastIdx) state_q <= StChk;
          end else if (rx_eop) begin
            err_frame <= 1'b1;
            state_q   <= StHunt;
          end
        end
        StChk: begin
          if (rx_ready) begin
            if (rx_data == acc_q) begin
              cmd_op    <= op_q;
              cmd_addr  <= addr_q;
              cmd_data  <= data_q;
              cmd_valid <= 1'b1;
              state_q   <= StHold;
            end else begin
              err_chk <= 1'b1;
              state_q <= StHunt;
            end
          end else if (rx_eop) begin
            err_frame <= 1'b1;
            state_q   <= StHunt;
          end
        end
        StHold: begin
          // cmd_valid is always high here, so cmd_ready alone marks the transfer
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (sync_hit) begin
              state_q <= StOp;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= StHunt;
            end
          end else if (rx_ready) begin
            err_ovr <= 1'b1;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command decoder sitting directly downstream of the UART receiver in the glitch/EXI control path. Consumes the receiver's byte strobe and end-of-packet strobe, frames fixed-length command packets (sync, opcode, address, 32-bit data, XOR checksum), and presents each validated command on a valid/ready interface to the register/control logic. Malformed, truncated or overrun packets are discarded and flagged with single-cycle error pulses.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- DATA_BYTES, 4, payload bytes per frame; fixed at 4 (cmd_data is 32 bits)

Ports:
- clk  in  1  system clock, same domain as the UART receiver
- rst_n  in  1  reset, asynchronous, active-low
- rx_ready  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- rx_eop  in  1  one-cycle strobe: inter-byte gap detected (end of packet)
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  consumer accepts command
- cmd_op  out  8  opcode
- cmd_addr  out  8  register address
- cmd_data  out  32  payload, little-endian (first payload byte -> [7:0])
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_frame  out  1  one-cycle pulse: rx_eop before frame complete
- err_ovr  out  1  one-cycle pulse: byte dropped while command pending
- busy  out  1  high whenever state != HUNT

## Operation
- Frame: SYNC, OP, ADDR, D0, D1, D2, D3, CHK. CHK = XOR of OP..D3, seed 8'h00.
- States: HUNT, OP, ADDR, DATA, CHK, HOLD. All transitions only on rx_ready except HOLD exit and abort.
- HUNT: byte == SYNC_BYTE -> OP, clear checksum accumulator and byte counter; other bytes dropped silently, no error.
- OP -> ADDR -> DATA: each byte latched into shadow register, XORed into accumulator.
- DATA: 2-bit counter; after 4th byte -> CHK. Counter wraps 3->0.
- CHK: byte == accumulator -> HOLD, load output registers, assert cmd_valid. Mismatch -> err_chk pulse, HUNT.
- Inside a frame a byte equal to SYNC_BYTE is ordinary data; no resync.
- rx_eop in OP/ADDR/DATA/CHK -> err_frame pulse, HUNT, partial frame discarded. rx_eop in HUNT/HOLD ignored.
- rx_ready and rx_eop same cycle: byte processed, rx_eop ignored.
- HOLD: cmd_valid high, cmd_op/addr/data stable until transfer (cmd_valid && cmd_ready). Any rx_ready in HOLD on a non-transfer cycle -> byte dropped, err_ovr pulse.
- Transfer cycle: state -> HUNT at that edge; an rx_ready on the transfer cycle is evaluated as in HUNT (SYNC accepted -> OP).
- busy = (state != HUNT), including HOLD.

## Timing
- Reset values: cmd_valid 0, cmd_op 0, cmd_addr 0, cmd_data 0, err_* 0, busy 0, state HUNT, accumulator 0.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; no error pulse emitted.
- cmd_valid rises on the edge after the CHK strobe cycle (latency 1 clk); all outputs registered.
- err_* asserted exactly 1 cycle, on the edge after the offending strobe; never two error pulses for one event.
- cmd_valid falls the edge after the transfer cycle; no combinational path cmd_ready -> cmd_valid.
- Throughput: one byte per rx_ready strobe; back-to-back strobes on consecutive cycles supported in every state.

## Structure
- Shared package uart_cmd_pkg: state enum, SYNC_BYTE default, frame length constant, opcode constants used by downstream register logic.
- Single module; no sub-module. Checksum accumulator and byte counter inline.

## Test plan
- Send A5 01 10 78 56 34 12 19 -> cmd_valid 1 cycle after last strobe, op 01, addr 10, data 32'h12345678, no error pulses; ready high -> valid drops next cycle.
- Same frame with CHK 18 -> err_chk single pulse, cmd_valid never asserted, busy 0 afterwards.
- Send A5 01 10 78 then rx_eop -> err_frame pulse, HUNT; following valid frame decodes correctly.
- cmd_ready low, valid frame, then byte 33 -> err_ovr pulse, outputs unchanged; ready high -> transfer; then A5 on the transfer cycle -> accepted as new frame start.
- Bytes 00 FF 5A then valid frame with data byte A5 inside (A5 02 20 A5 00 00 00 87) -> exactly one command, data 32'h000000A5, no errors.
- Assert rst_n low after A5 01 10 -> all outputs 0 immediately; after release a full frame decodes normally.
